sio_host_sched: RTL and testbench

Host-side command scheduler for the 128-clock remote IO (sio) frame. It shares the single command slot per frame between NREQ register-access requesters. Each frame it issues one 20-bit command (4-bit addr, 16-bit wdata) to the sio serializer. It returns the 16-bit readback word from that same frame to the requester that owned the command. Idle frames carry a harmless no-op command.

---
 rtl/sio_pkg.sv | 22 ++
 rtl/sio_rr_arbiter.sv | 30 +++
 rtl/sio_host_sched.sv | 111 +++++++++++
 tb/tb_sio_host_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sio_pkg.sv
// Shared constants and command payload for the 128-clock sio remote IO frame.
package sio_pkg;

  localparam int unsigned FRAME_CLOCKS = 128;
  localparam int unsigned ADDR_W       = 4;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned CMD_W        = ADDR_W + DATA_W;

  localparam logic [ADDR_W-1:0] IDLE_ADDR     = 4'hF;
  localparam logic [ADDR_W-1:0] ADDR_RESET    = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_SYNC     = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_ADC_SPI0 = 4'h2;
  localparam logic [ADDR_W-1:0] ADDR_ADC_SPI1 = 4'h3;
  localparam logic [ADDR_W-1:0] ADDR_ID       = 4'h4;
  localparam logic [DATA_W-1:0] ID_VALUE      = 16'hCAFE;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sio_cmd_t;

endpackage

// File: rtl/sio_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr.
module sio_rr_arbiter #(
  parameter  int unsigned NREQ  = 4,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt_c,
  output logic [IDX_W-1:0] gnt_idx_c,
  output logic             any_c
);

  int unsigned j;

  // Walk from the farthest slot back toward ptr so the nearest valid one wins.
  always_comb begin
    gnt_idx_c = '0;
    any_c     = 1'b0;
    j         = 0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      j = (32'(ptr) + 32'(k)) % NREQ;
      if (req[j]) begin
        gnt_idx_c = IDX_W'(j);
        any_c     = 1'b1;
      end
    end
    gnt_c = any_c ? (NREQ'(1) << gnt_idx_c) : '0;
  end

endmodule

// File: rtl/sio_host_sched.sv
// Host-side sio command scheduler: one round-robin grant per frame, readback
// routed to the owning requester, timeout reported at the next frame wrap.
module sio_host_sched
  import sio_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned FRAME     = FRAME_CLOCKS,
  parameter logic [3:0]  IDLE_ADDR = sio_pkg::IDLE_ADDR
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [4*NREQ-1:0]        req_addr,
  input  logic [16*NREQ-1:0]       req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic                     frame_start,
  output logic [3:0]               cmd_addr,
  output logic [15:0]              cmd_wdata,
  input  logic [15:0]              rx_rdata,
  input  logic                     rx_rdata_valid,
  output logic                     resp_valid,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [15:0]              resp_data,
  output logic                     resp_timeout,
  output logic [15:0]              timeout_count
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(FRAME);

  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] inflight_id;
  logic             inflight;

  logic [NREQ-1:0]  gnt_c;
  logic [IDX_W-1:0] gnt_idx_c;
  logic             gnt_any_c;
  logic             wrap_c;
  logic             rx_hit_c;
  sio_cmd_t         req_cmd [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_cmd[i] = {req_addr[4*i +: 4], req_wdata[16*i +: 16]};
  end

  assign wrap_c   = (count == CNT_W'(FRAME - 1));
  assign rx_hit_c = rx_rdata_valid && inflight;

  sio_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c),
    .any_c     (gnt_any_c)
  );

  // A grant at the wrap overrides the inflight clear from a same-cycle readback.
  always_ff @(posedge clock) begin
    if (reset) begin
      count         <= '0;
      rr_ptr        <= '0;
      inflight      <= 1'b0;
      inflight_id   <= '0;
      frame_start   <= 1'b0;
      req_ready     <= '0;
      cmd_addr      <= IDLE_ADDR;
      cmd_wdata     <= '0;
      resp_valid    <= 1'b0;
      resp_id       <= '0;
      resp_data     <= '0;
      resp_timeout  <= 1'b0;
      timeout_count <= '0;
    end else begin
      count        <= wrap_c ? '0 : count + CNT_W'(1);
      frame_start  <= wrap_c;
      req_ready    <= '0;
      resp_valid   <= 1'b0;
      resp_timeout <= 1'b0;

      if (rx_hit_c) begin
        resp_valid <= 1'b1;
        resp_id    <= inflight_id;
        resp_data  <= rx_rdata;
        inflight   <= 1'b0;
      end else if (wrap_c && inflight) begin
        resp_valid   <= 1'b1;
        resp_timeout <= 1'b1;
        resp_id      <= inflight_id;
        resp_data    <= '0;
        if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
      end

      if (wrap_c) begin
        if (gnt_any_c) begin
          cmd_addr    <= req_cmd[gnt_idx_c].addr;
          cmd_wdata   <= req_cmd[gnt_idx_c].wdata;
          req_ready   <= gnt_c;
          inflight    <= 1'b1;
          inflight_id <= gnt_idx_c;
          rr_ptr      <= IDX_W'((32'(gnt_idx_c) + 32'd1) % NREQ);
        end else begin
          cmd_addr  <= IDLE_ADDR;
          cmd_wdata <= '0;
          inflight  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sio_host_sched.sv
// Directed bench for sio_host_sched: frame-by-frame stimulus with hand-computed expectations.
module tb_sio_host_sched;

  localparam int NREQ  = 4;
  localparam int FRAME = 128;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_ready;
  logic        frame_start;
  logic [3:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic [15:0] rx_rdata;
  logic        rx_rdata_valid;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [15:0] resp_data;
  logic        resp_timeout;
  logic [15:0] timeout_count;

  int n_checks;
  int n_fail;

  int          n_resp, fs_bad, rdy_bad, cmd_bad;
  logic [31:0] f_id, f_data, f_to;
  logic [31:0] w_fs, w_rdy, w_rv, w_rid, w_rdata, w_rto, w_tcnt, w_addr, w_wdata;
  logic [3:0]  ea;
  logic [15:0] ew;

  always #16 clock = ~clock;

  sio_host_sched #(.NREQ(NREQ), .FRAME(FRAME), .IDLE_ADDR(4'hF)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .frame_start    (frame_start),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rx_rdata       (rx_rdata),
    .rx_rdata_valid (rx_rdata_valid),
    .resp_valid     (resp_valid),
    .resp_id        (resp_id),
    .resp_data      (resp_data),
    .resp_timeout   (resp_timeout),
    .timeout_count  (timeout_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [15:0] d);
    req_valid[i]        = 1'b1;
    req_addr[4*i +: 4]  = a;
    req_wdata[16*i +: 16] = d;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_fs"},    32'(frame_start),   0);
    chk({tag, "_rdy"},   32'(req_ready),     0);
    chk({tag, "_rv"},    32'(resp_valid),    0);
    chk({tag, "_rto"},   32'(resp_timeout),  0);
    chk({tag, "_rid"},   32'(resp_id),       0);
    chk({tag, "_rdata"}, 32'(resp_data),     0);
    chk({tag, "_addr"},  32'(cmd_addr),      32'hF);
    chk({tag, "_wdata"}, 32'(cmd_wdata),     0);
    chk({tag, "_tcnt"},  32'(timeout_count), 0);
  endtask

  // Runs one frame from count 0 through the next wrap; rx pulses sampled at count rx_a / rx_b.
  task automatic run_frame(input int rx_a, input int rx_b, input logic [15:0] rd,
                           input logic [3:0] exp_addr, input logic [15:0] exp_wdata);
    n_resp = 0; fs_bad = 0; rdy_bad = 0; cmd_bad = 0;
    f_id = 0; f_data = 0; f_to = 0;
    for (int p = 0; p < FRAME; p++) begin
      rx_rdata_valid = (p == rx_a) || (p == rx_b);
      rx_rdata       = rd;
      tick;
      if (p < FRAME - 1) begin
        if (resp_valid) begin
          n_resp++;
          f_id = 32'(resp_id); f_data = 32'(resp_data); f_to = 32'(resp_timeout);
        end
        if (frame_start) fs_bad++;
        if (req_ready != 4'b0) rdy_bad++;
        if (cmd_addr != exp_addr || cmd_wdata != exp_wdata) cmd_bad++;
      end else begin
        w_fs = 32'(frame_start); w_rdy = 32'(req_ready); w_rv = 32'(resp_valid);
        w_rid = 32'(resp_id); w_rdata = 32'(resp_data); w_rto = 32'(resp_timeout);
        w_tcnt = 32'(timeout_count); w_addr = 32'(cmd_addr); w_wdata = 32'(cmd_wdata);
      end
    end
    rx_rdata_valid = 1'b0;
  endtask

  initial begin
    #(32 * 20000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; req_valid = '0; req_addr = '0; req_wdata = '0;
    rx_rdata_valid = 1'b0; rx_rdata = '0;
    tick; tick;
    reset = 1'b0;
    check_reset("rst");

    // Single requester 1, answered 40 cycles into its frame.
    set_req(1, 4'h4, 16'h1234);
    run_frame(-1, -1, 16'h0, 4'hF, 16'h0);
    chk("t1_no_early_fs", 32'(fs_bad), 0);
    chk("t1_fs", w_fs, 1);
    chk("t1_rdy", w_rdy, 32'b0010);
    chk("t1_addr", w_addr, 32'h4);
    chk("t1_wdata", w_wdata, 32'h1234);
    chk("t1_rv_wrap", w_rv, 0);
    req_valid = '0;
    run_frame(40, -1, 16'hCAFE, 4'h4, 16'h1234);
    chk("t1_cmd_hold", 32'(cmd_bad), 0);
    chk("t1_nresp", 32'(n_resp), 1);
    chk("t1_rid", f_id, 1);
    chk("t1_rdata", f_data, 32'hCAFE);
    chk("t1_rto", f_to, 0);
    chk("t1_rdy_mid", 32'(rdy_bad), 0);
    chk("t1_fs_mid", 32'(fs_bad), 0);
    chk("t1_fs2", w_fs, 1);
    chk("t1_rv2", w_rv, 0);
    chk("t1_idle_addr", w_addr, 32'hF);
    chk("t1_idle_wdata", w_wdata, 0);
    chk("t1_rdy2", w_rdy, 0);

    // Idle frame with stray readback pulses.
    run_frame(10, 70, 16'h5555, 4'hF, 16'h0);
    chk("t3_nresp", 32'(n_resp), 0);
    chk("t3_cmd", 32'(cmd_bad), 0);
    chk("t3_rdy_mid", 32'(rdy_bad), 0);
    chk("t3_rv_wrap", w_rv, 0);
    chk("t3_rdy", w_rdy, 0);
    chk("t3_addr", w_addr, 32'hF);

    // Requester 2 granted, never answered; requester 3 granted at the timeout wrap.
    set_req(2, 4'h9, 16'hABCD);
    run_frame(-1, -1, 16'h0, 4'hF, 16'h0);
    chk("t4_rdy", w_rdy, 32'b0100);
    chk("t4_addr", w_addr, 32'h9);
    chk("t4_wdata", w_wdata, 32'hABCD);
    chk("t4_rv0", w_rv, 0);
    req_valid = '0;
    set_req(3, 4'h7, 16'h0777);
    run_frame(-1, -1, 16'h0, 4'h9, 16'hABCD);
    chk("t4_nresp", 32'(n_resp), 0);
    chk("t4_rv", w_rv, 1);
    chk("t4_rto", w_rto, 1);
    chk("t4_rdata", w_rdata, 0);
    chk("t4_rid", w_rid, 2);
    chk("t4_tcnt", w_tcnt, 1);
    chk("t4_rdy_new", w_rdy, 32'b1000);
    chk("t4_addr_new", w_addr, 32'h7);
    chk("t4_wdata_new", w_wdata, 32'h0777);
    req_valid = '0;

    // Readback in the last cycle of the frame while requester 0 wins the next slot.
    set_req(0, 4'h3, 16'h0042);
    run_frame(FRAME - 1, -1, 16'hBEEF, 4'h7, 16'h0777);
    chk("t5_nresp", 32'(n_resp), 0);
    chk("t5_rv", w_rv, 1);
    chk("t5_rto", w_rto, 0);
    chk("t5_rid", w_rid, 3);
    chk("t5_rdata", w_rdata, 32'hBEEF);
    chk("t5_tcnt", w_tcnt, 1);
    chk("t5_rdy", w_rdy, 32'b0001);
    chk("t5_addr", w_addr, 32'h3);
    req_valid = '0;
    run_frame(20, 50, 16'h1111, 4'h3, 16'h0042);
    chk("t5_nresp2", 32'(n_resp), 1);
    chk("t5_rid2", f_id, 0);
    chk("t5_rdata2", f_data, 32'h1111);
    chk("t5_rto2", f_to, 0);
    chk("t5_rv_wrap2", w_rv, 0);
    chk("t5_tcnt2", w_tcnt, 1);

    // Reset at count 60 with requester 1 in flight.
    set_req(1, 4'h2, 16'h0055);
    run_frame(-1, -1, 16'h0, 4'hF, 16'h0);
    chk("t6_rdy", w_rdy, 32'b0010);
    req_valid = '0;
    repeat (60) tick;
    reset = 1'b1;
    tick;
    check_reset("t6_rst");
    tick;
    reset = 1'b0;
    run_frame(-1, -1, 16'h0, 4'hF, 16'h0);
    chk("t6_no_early_fs", 32'(fs_bad), 0);
    chk("t6_nresp", 32'(n_resp), 0);
    chk("t6_fs", w_fs, 1);
    chk("t6_rv", w_rv, 0);
    chk("t6_tcnt", w_tcnt, 0);
    chk("t6_rdy", w_rdy, 0);

    // All four continuously valid for eight frames; each answered at count 30.
    for (int i = 0; i < NREQ; i++) set_req(i, 4'(i + 8), 16'(16'h1000 + i));
    ea = 4'hF; ew = 16'h0;
    for (int f = 0; f < 8; f++) begin
      run_frame(30, -1, 16'(16'hD000 + f), ea, ew);
      if (f > 0) begin
        chk($sformatf("t2_nresp%0d", f), 32'(n_resp), 1);
        chk($sformatf("t2_rid%0d", f), f_id, 32'((f - 1) % 4));
        chk($sformatf("t2_rdata%0d", f), f_data, 32'(16'hD000 + f));
      end else begin
        chk("t2_nresp0", 32'(n_resp), 0);
      end
      chk($sformatf("t2_cmd%0d", f), 32'(cmd_bad), 0);
      chk($sformatf("t2_rdy%0d", f), w_rdy, 32'(1 << (f % 4)));
      chk($sformatf("t2_addr%0d", f), w_addr, 32'(8 + f % 4));
      chk($sformatf("t2_rv%0d", f), w_rv, 0);
      ea = 4'(8 + f % 4);
      ew = 16'(16'h1000 + f % 4);
    end
    req_valid = '0;
    run_frame(30, -1, 16'hD008, ea, ew);
    chk("t2_nresp_last", 32'(n_resp), 1);
    chk("t2_rid_last", f_id, 3);
    chk("t2_rdata_last", f_data, 32'hD008);
    chk("t2_rdy_last", w_rdy, 0);
    chk("t2_tcnt", 32'(timeout_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
